multi_timer: RTL and testbench



---
 rtl/multi_timer_pkg.sv | 20 ++
 rtl/multi_timer_ch.sv | 106 ++++++++++
 rtl/multi_timer.sv | 44 ++++
 tb/tb_multi_timer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg -- shared types and constants for the multi-channel timer.
//   state_t        : per-channel FSM state (IDLE / RUN)
//   CPT_SIM/BOARD  : clock cycles per tick for simulation and for the board
//   psc_width()    : prescaler counter width for a given cycles-per-tick
package multi_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int CPT_SIM   = 10;
  localparam int CPT_BOARD = 100_000_000;

  // Width of a counter holding 0..cpt-1; at least one bit.
  function automatic int psc_width(input int cpt);
    return (cpt < 2) ? 1 : $clog2(cpt);
  endfunction

endpackage

// File: rtl/multi_timer_ch.sv
// multi_timer_ch -- one independent one-shot delay timer channel.
//   clk, rst   : clock, synchronous active-high reset
//   start      : start level; a 0->1 transition triggers
//   delay      : delay in ticks, sampled only on the trigger cycle
//   abort      : level abort, returns the channel to idle without done
//   out_sig    : high while running
//   done       : one-cycle pulse on natural expiry (or zero-delay trigger)
//   remaining  : ticks left including the current partial tick, 0 when idle
// Build option MULTI_TIMER_RETRIGGER_EN: a start edge while running reloads
// the delay instead of being ignored.
module multi_timer_ch
  import multi_timer_pkg::*;
#(
  parameter int DELAY_W             = 5,
  parameter int CLK_CYCLES_PER_TICK = CPT_SIM
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DELAY_W-1:0] delay,
  input  logic               abort,
  output logic               out_sig,
  output logic               done,
  output logic [DELAY_W-1:0] remaining
);

  localparam int              PSC_W    = psc_width(CLK_CYCLES_PER_TICK);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLK_CYCLES_PER_TICK - 1);

  state_t           state;
  logic [PSC_W-1:0] psc;
  logic             start_q;
  logic             trig;

  assign trig = start & ~start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      psc       <= '0;
      remaining <= '0;
      out_sig   <= 1'b0;
      done      <= 1'b0;
      // All ones so a start level held across reset release cannot trigger.
      start_q   <= 1'b1;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      if (abort) begin
        // Abort beats any simultaneous edge; in idle this is a no-op.
        state     <= ST_IDLE;
        psc       <= '0;
        remaining <= '0;
        out_sig   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (trig) begin
              if (delay != '0) begin
                state     <= ST_RUN;
                out_sig   <= 1'b1;
                remaining <= delay;
                psc       <= '0;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ST_RUN: begin
`ifdef MULTI_TIMER_RETRIGGER_EN
            if (trig) begin
              psc <= '0;
              if (delay != '0) begin
                remaining <= delay;
              end else begin
                state     <= ST_IDLE;
                out_sig   <= 1'b0;
                remaining <= '0;
                done      <= 1'b1;
              end
            end else
`endif
            if (psc == PSC_LAST) begin
              psc <= '0;
              if (remaining == DELAY_W'(1)) begin
                state     <= ST_IDLE;
                out_sig   <= 1'b0;
                remaining <= '0;
                done      <= 1'b1;
              end else if (remaining != '0) begin
                remaining <= remaining - DELAY_W'(1);
              end
            end else begin
              psc <= psc + PSC_W'(1);
            end
          end
          default: begin
            state   <= ST_IDLE;
            out_sig <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_timer.sv
// multi_timer -- NUM_CH independent one-shot delay timers.
//   clk, rst   : clock, synchronous active-high reset
//   start      : [NUM_CH] per-channel start level (rising edge triggers)
//   delay      : [NUM_CH*DELAY_W] channel i at [i*DELAY_W +: DELAY_W]
//   abort      : [NUM_CH] per-channel level abort
//   out_sig    : [NUM_CH] high while channel runs
//   done       : [NUM_CH] one-cycle expiry pulse
//   remaining  : [NUM_CH*DELAY_W] ticks left per channel
// Build option MULTI_TIMER_RETRIGGER_EN: restart a running channel on a
// new start edge (handled inside multi_timer_ch).
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH              = 4,
  parameter int DELAY_W             = 5,
  parameter int CLK_CYCLES_PER_TICK = CPT_SIM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH*DELAY_W-1:0] delay,
  input  logic [NUM_CH-1:0]         abort,
  output logic [NUM_CH-1:0]         out_sig,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH*DELAY_W-1:0] remaining
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_timer_ch #(
      .DELAY_W             (DELAY_W),
      .CLK_CYCLES_PER_TICK (CLK_CYCLES_PER_TICK)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .start     (start[i]),
      .delay     (delay[i*DELAY_W +: DELAY_W]),
      .abort     (abort[i]),
      .out_sig   (out_sig[i]),
      .done      (done[i]),
      .remaining (remaining[i*DELAY_W +: DELAY_W])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer -- scenario bench for multi_timer (4 ch, 5-bit delay, 10 cpt).
// Each step drives inputs, pushes the expected post-edge outputs onto a
// scoreboard queue, clocks once and pops/compares on the falling edge.
module tb_multi_timer;

  localparam int NC  = 4;
  localparam int DW  = 5;
  localparam int CPT = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic [NC-1:0]      start;
  logic [NC*DW-1:0]   delay;
  logic [NC-1:0]      abort;
  logic [NC-1:0]      out_sig;
  logic [NC-1:0]      done;
  logic [NC*DW-1:0]   remaining;

  typedef struct packed {
    logic [NC-1:0]    out;
    logic [NC-1:0]    dn;
    logic [NC*DW-1:0] rem;
  } exp_t;

  exp_t sbq[$];
  exp_t e, g;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multi_timer #(
    .NUM_CH(NC), .DELAY_W(DW), .CLK_CYCLES_PER_TICK(CPT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .delay(delay), .abort(abort),
    .out_sig(out_sig), .done(done), .remaining(remaining)
  );

  // Expected channel outputs at cycle k for an edge sampled at cycle ed
  // with delay d: high ed+1 .. ed+d*CPT, done at ed+1+d*CPT (ed+1 if d==0).
  function automatic void exp_ch(input int k, input int ed, input int d,
                                 output logic o, output logic dn,
                                 output logic [DW-1:0] r);
    o  = (d > 0) && (k >= ed + 1) && (k <= ed + d * CPT);
    dn = (d == 0) ? (k == ed + 1) : (k == ed + 1 + d * CPT);
    r  = o ? DW'(d - (k - ed - 1) / CPT) : '0;
  endfunction

  function automatic exp_t exp_all(input int k, input int ed[NC], input int d[NC]);
    exp_t x;
    logic o, dn;
    logic [DW-1:0] r;
    x = '0;
    for (int i = 0; i < NC; i++) begin
      exp_ch(k, ed[i], d[i], o, dn, r);
      x.out[i] = o;
      x.dn[i]  = dn;
      x.rem[i*DW +: DW] = r;
    end
    return x;
  endfunction

  localparam int NEVER = -1000;

  task automatic test_reset();
    for (int j = 0; j < 2; j++) begin
      sbq.push_back('0);
      @(posedge clk); @(negedge clk);
      g = sbq.pop_front(); n_vec++;
      if ({out_sig, done, remaining} !== g) begin
        n_err++;
        $display("FAIL reset step=%0d got out=%b done=%b rem=%h want out=%b done=%b rem=%h",
                 j, out_sig, done, remaining, g.out, g.dn, g.rem);
      end
    end
  endtask

  // Start held high through reset release, then a common edge at step 11.
  task automatic test_held_start();
    int ed[NC], d[NC];
    rst = 1'b0;
    delay = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int j = 0; j < 56; j++) begin
      start = (j == 10 || j >= 50) ? 4'h0 : 4'hF;
      for (int i = 0; i < NC; i++) begin
        ed[i] = (j >= 11) ? 11 : NEVER;
        d[i]  = i + 1;
      end
      sbq.push_back(exp_all(j + 1, ed, d));
      @(posedge clk); @(negedge clk);
      g = sbq.pop_front(); n_vec++;
      if ({out_sig, done, remaining} !== g) begin
        n_err++;
        $display("FAIL held_start k=%0d got out=%b done=%b rem=%h want out=%b done=%b rem=%h",
                 j + 1, out_sig, done, remaining, g.out, g.dn, g.rem);
      end
    end
  endtask

  // ch0 delay 3; delay bus changes after the trigger and must be ignored.
  task automatic test_single();
    int ed[NC], d[NC];
    ed = '{0, NEVER, NEVER, NEVER};
    d  = '{3, 0, 0, 0};
    for (int j = 0; j < 40; j++) begin
      start = (j < 5) ? 4'h1 : 4'h0;
      delay = (j == 0) ? 20'd3 : {5'd9, 5'd9, 5'd9, 5'd7};
      sbq.push_back(exp_all(j + 1, ed, d));
      @(posedge clk); @(negedge clk);
      g = sbq.pop_front(); n_vec++;
      if ({out_sig, done, remaining} !== g) begin
        n_err++;
        $display("FAIL single k=%0d got out=%b done=%b rem=%h want out=%b done=%b rem=%h",
                 j + 1, out_sig, done, remaining, g.out, g.dn, g.rem);
      end
    end
  endtask

  task automatic test_zero_delay();
    int ed[NC], d[NC];
    ed = '{NEVER, 0, NEVER, NEVER};
    d  = '{0, 0, 0, 0};
    delay = '0;
    for (int j = 0; j < 6; j++) begin
      start = (j < 2) ? 4'h2 : 4'h0;
      sbq.push_back(exp_all(j + 1, ed, d));
      @(posedge clk); @(negedge clk);
      g = sbq.pop_front(); n_vec++;
      if ({out_sig, done, remaining} !== g) begin
        n_err++;
        $display("FAIL zero_delay k=%0d got out=%b done=%b rem=%h want out=%b done=%b rem=%h",
                 j + 1, out_sig, done, remaining, g.out, g.dn, g.rem);
      end
    end
  endtask

  // ch2 delay 5 aborted at step 17, re-run with delay 1 at step 25;
  // abort on idle ch3 at step 5 must do nothing.
  task automatic test_abort();
    int ed[NC], d[NC];
    for (int j = 0; j < 40; j++) begin
      start = (j < 2 || j == 25 || j == 26) ? 4'h4 : 4'h0;
      delay = (j < 25) ? (20'd5 << 10) : (20'd1 << 10);
      abort = (j == 17) ? 4'h4 : (j == 5) ? 4'h8 : 4'h0;
      ed = '{NEVER, NEVER, 0, NEVER};
      d  = '{0, 0, 5, 0};
      if (j + 1 >= 18) begin
        ed[2] = (j + 1 > 25) ? 25 : NEVER;
        d[2]  = 1;
      end
      sbq.push_back(exp_all(j + 1, ed, d));
      @(posedge clk); @(negedge clk);
      g = sbq.pop_front(); n_vec++;
      if ({out_sig, done, remaining} !== g) begin
        n_err++;
        $display("FAIL abort k=%0d got out=%b done=%b rem=%h want out=%b done=%b rem=%h",
                 j + 1, out_sig, done, remaining, g.out, g.dn, g.rem);
      end
    end
    abort = '0;
  endtask

  // ch3 delay 4, second edge at step 25 with delay 2.
  task automatic test_retrigger();
    int ed[NC], d[NC];
    for (int j = 0; j < 50; j++) begin
      start = (j < 2 || j == 25 || j == 26) ? 4'h8 : 4'h0;
      delay = (j < 25) ? (20'd4 << 15) : (20'd2 << 15);
      ed = '{NEVER, NEVER, NEVER, 0};
      d  = '{0, 0, 0, 4};
`ifdef MULTI_TIMER_RETRIGGER_EN
      if (j + 1 > 25) begin
        ed[3] = 25;
        d[3]  = 2;
      end
`endif
      sbq.push_back(exp_all(j + 1, ed, d));
      @(posedge clk); @(negedge clk);
      g = sbq.pop_front(); n_vec++;
      if ({out_sig, done, remaining} !== g) begin
        n_err++;
        $display("FAIL retrigger k=%0d got out=%b done=%b rem=%h want out=%b done=%b rem=%h",
                 j + 1, out_sig, done, remaining, g.out, g.dn, g.rem);
      end
    end
  endtask

  // All channels running; rst plus abort and start edge on ch0 at step 5.
  task automatic test_rst_mid();
    int ed[NC], d[NC];
    delay = {5'd3, 5'd3, 5'd3, 5'd3};
    for (int j = 0; j < 30; j++) begin
      start = (j == 3 || j == 4) ? 4'hE : (j >= 25) ? 4'h0 : 4'hF;
      rst   = (j == 5 || j == 6);
      abort = (j == 5) ? 4'h1 : 4'h0;
      ed = '{0, 0, 0, 0};
      d  = '{3, 3, 3, 3};
      if (j + 1 >= 6) ed = '{NEVER, NEVER, NEVER, NEVER};
      sbq.push_back(exp_all(j + 1, ed, d));
      @(posedge clk); @(negedge clk);
      g = sbq.pop_front(); n_vec++;
      if ({out_sig, done, remaining} !== g) begin
        n_err++;
        $display("FAIL rst_mid k=%0d got out=%b done=%b rem=%h want out=%b done=%b rem=%h",
                 j + 1, out_sig, done, remaining, g.out, g.dn, g.rem);
      end
    end
    rst = 1'b0;
    abort = '0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 4'hF;
    delay = '0;
    abort = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_held_start();
    test_single();
    test_zero_delay();
    test_abort();
    test_retrigger();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
